// File: rtl/fifo_ptr_pkg.sv
// ----------------------------------------------------------------------------
// fifo_ptr_pkg
//
// Shared definitions for the FIFO pointer controller slice.
//   - clog2        : constant function used to size count and address ports.
//   - DEPTH_MIN/MAX: legal range of the DEPTH parameter, checked at elaboration.
// ----------------------------------------------------------------------------
package fifo_ptr_pkg;

   localparam int unsigned DEPTH_MIN = 2;
   localparam int unsigned DEPTH_MAX = 256;

   // Ceiling log2. The result is 0 for value <= 1. Callers only pass
   // DEPTH and DEPTH+1, both of which are >= 2, so every width is >= 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/rise_strobe.sv
// ----------------------------------------------------------------------------
// rise_strobe
//
// Converts a level request into a single-cycle pulse on its rising edge.
// With FIFO_PTR_SYNC_EN defined, the input first passes through a 2-flop
// synchroniser, which adds two cycles of latency to the pulse.
//
// The history register and the synchroniser flops reset to 1. A request
// that is already high when reset is released is therefore treated as old
// and produces no pulse.
//
// Ports:
//   clk    in   system clock, posedge
//   rst_n  in   asynchronous active-low reset
//   sig    in   level request
//   pulse  out  one-cycle strobe, combinational from the (synchronised) level
//
// Configuration macro: FIFO_PTR_SYNC_EN (enables the input synchroniser).
// ----------------------------------------------------------------------------
module rise_strobe (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic pulse
);

   logic sig_s;
   logic hist_q;

`ifdef FIFO_PTR_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], sig};
      end
   end

   assign sig_s = sync_q[1];
`else
   assign sig_s = sig;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= 1'b1;
      end else begin
         hist_q <= sig_s;
      end
   end

   assign pulse = sig_s & ~hist_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_ptr_ctrl
//
// Parametrised FIFO occupancy and pointer controller. It turns rising edges
// on the write/read triggers into accepted storage strobes. It tracks an
// occupancy of 0..DEPTH and maintains circular read/write addresses for RAM
// storage plus a tap index for shift-register storage.
//
// Parameters:
//   DEPTH      number of entries, 2..256, any value (not only powers of two)
//   AF_THRESH  almost_full asserts when count >= AF_THRESH, 1..DEPTH
//   CNT_W      derived width of count
//   ADDR_W     derived width of wr_addr/rd_addr/tap
//
// Ports:
//   clk          in   system clock, posedge
//   rst_n        in   asynchronous active-low reset
//   trig_write   in   write request, rising edge = one write
//   trig_read    in   read request, rising edge = one read
//   err_clr      in   synchronous clear of overflow/underflow
//   fifo_clk     out  one-cycle storage write enable per accepted write
//   rd_ack       out  one-cycle pulse per accepted read
//   count        out  current occupancy
//   tap          out  shift-register read index (count-1, 0 when empty)
//   wr_addr      out  next write slot
//   rd_addr      out  next read slot
//   empty        out  count == 0
//   full         out  count == DEPTH
//   almost_full  out  count >= AF_THRESH
//   overflow     out  sticky, a write was rejected
//   underflow    out  sticky, a read was rejected
//
// Configuration macro: FIFO_PTR_SYNC_EN. It adds a 2-flop synchroniser per
// trigger inside rise_strobe, which delays the strobes by 2 clk.
// ----------------------------------------------------------------------------
module fifo_ptr_ctrl
   import fifo_ptr_pkg::*;
#(
   parameter  int unsigned DEPTH     = 4,
   parameter  int unsigned AF_THRESH = 3,
   localparam int unsigned CNT_W     = clog2(DEPTH + 1),
   localparam int unsigned ADDR_W    = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trig_write,
   input  logic              trig_read,
   input  logic              err_clr,
   output logic              fifo_clk,
   output logic              rd_ack,
   output logic [CNT_W-1:0]  count,
   output logic [ADDR_W-1:0] tap,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              overflow,
   output logic              underflow
);

   // -------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // -------------------------------------------------------------------------
   if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
      $error("fifo_ptr_ctrl: DEPTH out of legal range");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("fifo_ptr_ctrl: AF_THRESH out of legal range");
   end

   localparam logic [CNT_W-1:0]  CntDepth = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CntAf    = CNT_W'(AF_THRESH);
   localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(DEPTH - 1);

   // -------------------------------------------------------------------------
   // Edge detection
   // -------------------------------------------------------------------------
   logic wr_req;
   logic rd_req;

   rise_strobe u_rise_wr (
      .clk   (clk),
      .rst_n (rst_n),
      .sig   (trig_write),
      .pulse (wr_req)
   );

   rise_strobe u_rise_rd (
      .clk   (clk),
      .rst_n (rst_n),
      .sig   (trig_read),
      .pulse (rd_req)
   );

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [CNT_W-1:0]  count_q,   count_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              empty_q,   empty_d;
   logic              full_q,    full_d;
   logic              af_q,      af_d;
   logic              ovf_q,     ovf_d;
   logic              unf_q,     unf_d;
   logic              wr_acc;
   logic              rd_acc;

   // -------------------------------------------------------------------------
   // Acceptance and next state
   // -------------------------------------------------------------------------
   always_comb begin
      // A write at full is still taken when a read leaves in the same cycle.
      // Storage is read-before-write, so the slot is vacated in time.
      // A read at empty is never taken. A simultaneous write cannot supply
      // data in the same cycle.
      wr_acc = wr_req & (~full_q | rd_req);
      rd_acc = rd_req & ~empty_q;

      count_d = count_q;
      if (wr_acc && !rd_acc) begin
         count_d = count_q + CNT_W'(1);
      end else if (!wr_acc && rd_acc) begin
         count_d = count_q - CNT_W'(1);
      end

      // Explicit wrap so non-power-of-two depths stay in range.
      wr_addr_d = wr_addr_q;
      if (wr_acc) begin
         wr_addr_d = (wr_addr_q == AddrLast) ? '0 : wr_addr_q + ADDR_W'(1);
      end

      rd_addr_d = rd_addr_q;
      if (rd_acc) begin
         rd_addr_d = (rd_addr_q == AddrLast) ? '0 : rd_addr_q + ADDR_W'(1);
      end

      // Flags come from count_d so they change on the same edge as count.
      empty_d = (count_d == '0);
      full_d  = (count_d == CntDepth);
      af_d    = (count_d >= CntAf);

      // Set wins over a coincident clear.
      ovf_d = (ovf_q & ~err_clr) | (wr_req & ~wr_acc);
      unf_d = (unf_q & ~err_clr) | (rd_req & ~rd_acc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         af_q      <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
         af_q      <= af_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign fifo_clk    = wr_acc;
   assign rd_ack      = rd_acc;
   assign count       = count_q;
   assign wr_addr     = wr_addr_q;
   assign rd_addr     = rd_addr_q;
   assign empty       = empty_q;
   assign full        = full_q;
   assign almost_full = af_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;

   // The newest entry of a shift register sits at index count-1.
   assign tap = empty_q ? '0 : ADDR_W'(count_q - CNT_W'(1));

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fifo_ptr_ctrl
//
// Two controllers share one stimulus stream. The first has DEPTH=4 and
// AF_THRESH=3. The second has DEPTH=5 and AF_THRESH=4, so it also exercises
// a non-power-of-two wrap. Each cycle the driver updates the reference model
// and queues the values expected to be visible mid-cycle. A monitor pops the
// queue on every falling edge and compares.
// ----------------------------------------------------------------------------
module tb_fifo_ptr_ctrl;

   localparam int unsigned D0 = 4;
   localparam int unsigned A0 = 3;
   localparam int unsigned D1 = 5;
   localparam int unsigned A1 = 4;

   logic clk;
   logic rst_n;
   logic trig_write;
   logic trig_read;
   logic err_clr;

   logic       fclk0, rack0, emp0, ful0, af0, ovf0, unf0;
   logic [2:0] cnt0;
   logic [1:0] tap0, wa0, ra0;
   logic       fclk1, rack1, emp1, ful1, af1, ovf1, unf1;
   logic [2:0] cnt1;
   logic [2:0] tap1, wa1, ra1;

   fifo_ptr_ctrl #(.DEPTH(D0), .AF_THRESH(A0)) u_dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .trig_write  (trig_write),
      .trig_read   (trig_read),
      .err_clr     (err_clr),
      .fifo_clk    (fclk0),
      .rd_ack      (rack0),
      .count       (cnt0),
      .tap         (tap0),
      .wr_addr     (wa0),
      .rd_addr     (ra0),
      .empty       (emp0),
      .full        (ful0),
      .almost_full (af0),
      .overflow    (ovf0),
      .underflow   (unf0)
   );

   fifo_ptr_ctrl #(.DEPTH(D1), .AF_THRESH(A1)) u_dut5 (
      .clk         (clk),
      .rst_n       (rst_n),
      .trig_write  (trig_write),
      .trig_read   (trig_read),
      .err_clr     (err_clr),
      .fifo_clk    (fclk1),
      .rd_ack      (rack1),
      .count       (cnt1),
      .tap         (tap1),
      .wr_addr     (wa1),
      .rd_addr     (ra1),
      .empty       (emp1),
      .full        (ful1),
      .almost_full (af1),
      .overflow    (ovf1),
      .underflow   (unf1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // -------------------------------------------------------------------------
   // Scoreboard
   // -------------------------------------------------------------------------
   typedef struct {
      int inst;
      int wstb;
      int rstb;
      int count;
      int tap;
      int wa;
      int ra;
      int empty;
      int full;
      int af;
      int ovf;
      int unf;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input int inst, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
      end
   endtask

   // -------------------------------------------------------------------------
   // Reference model: occupancy and modular slot indices
   // -------------------------------------------------------------------------
   int m_cnt[2];
   int m_wa[2];
   int m_ra[2];
   int m_ovf[2];
   int m_unf[2];
   bit prev_w = 1'b1;
   bit prev_r = 1'b1;

   task automatic model_step(input int k, input bit tw, input bit tr, input bit clr,
                             input bit rstn);
      exp_t e;
      int   d;
      int   a;
      bit   wreq, rreq, wacc, racc;
      d = (k == 0) ? int'(D0) : int'(D1);
      a = (k == 0) ? int'(A0) : int'(A1);
      if (!rstn) begin
         m_cnt[k] = 0;
         m_wa[k]  = 0;
         m_ra[k]  = 0;
         m_ovf[k] = 0;
         m_unf[k] = 0;
      end
      wreq = rstn && tw && !prev_w;
      rreq = rstn && tr && !prev_r;
      wacc = 1'b0;
      racc = 1'b0;
      if (wreq && rreq) begin
         wacc = 1'b1;
         racc = (m_cnt[k] != 0);
      end else if (wreq) begin
         wacc = (m_cnt[k] < d);
      end else if (rreq) begin
         racc = (m_cnt[k] > 0);
      end

      e.inst  = k;
      e.wstb  = int'(wacc);
      e.rstb  = int'(racc);
      e.count = m_cnt[k];
      e.tap   = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
      e.wa    = m_wa[k];
      e.ra    = m_ra[k];
      e.empty = int'(m_cnt[k] == 0);
      e.full  = int'(m_cnt[k] == d);
      e.af    = int'(m_cnt[k] >= a);
      e.ovf   = m_ovf[k];
      e.unf   = m_unf[k];
      sb_q.push_back(e);

      if (rstn) begin
         m_cnt[k] = m_cnt[k] + int'(wacc) - int'(racc);
         m_wa[k]  = (m_wa[k] + int'(wacc)) % d;
         m_ra[k]  = (m_ra[k] + int'(racc)) % d;
         if (clr) begin
            m_ovf[k] = 0;
            m_unf[k] = 0;
         end
         if (wreq && !wacc) m_ovf[k] = 1;
         if (rreq && !racc) m_unf[k] = 1;
      end
   endtask

   // Apply one cycle of inputs just after the rising edge.
   task automatic drive(input bit tw, input bit tr, input bit clr, input bit rstn);
      @(posedge clk);
      #1;
      trig_write = tw;
      trig_read  = tr;
      err_clr    = clr;
      rst_n      = rstn;
      model_step(0, tw, tr, clr, rstn);
      model_step(1, tw, tr, clr, rstn);
      prev_w = rstn ? tw : 1'b1;
      prev_r = rstn ? tr : 1'b1;
   endtask

   task automatic wr_pulse();
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic rd_pulse();
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic both_pulse();
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // -------------------------------------------------------------------------
   // Monitor
   // -------------------------------------------------------------------------
   always @(negedge clk) begin
      exp_t e;
      int   a_ws, a_rs, a_cnt, a_tap, a_wa, a_ra, a_emp, a_ful, a_af, a_ovf, a_unf;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (e.inst == 0) begin
            a_ws = int'(fclk0); a_rs = int'(rack0); a_cnt = int'(cnt0); a_tap = int'(tap0);
            a_wa = int'(wa0);   a_ra = int'(ra0);   a_emp = int'(emp0); a_ful = int'(ful0);
            a_af = int'(af0);   a_ovf = int'(ovf0); a_unf = int'(unf0);
         end else begin
            a_ws = int'(fclk1); a_rs = int'(rack1); a_cnt = int'(cnt1); a_tap = int'(tap1);
            a_wa = int'(wa1);   a_ra = int'(ra1);   a_emp = int'(emp1); a_ful = int'(ful1);
            a_af = int'(af1);   a_ovf = int'(ovf1); a_unf = int'(unf1);
         end
         chk("fifo_clk",    e.inst, a_ws,  e.wstb);
         chk("rd_ack",      e.inst, a_rs,  e.rstb);
         chk("count",       e.inst, a_cnt, e.count);
         chk("tap",         e.inst, a_tap, e.tap);
         chk("wr_addr",     e.inst, a_wa,  e.wa);
         chk("rd_addr",     e.inst, a_ra,  e.ra);
         chk("empty",       e.inst, a_emp, e.empty);
         chk("full",        e.inst, a_ful, e.full);
         chk("almost_full", e.inst, a_af,  e.af);
         chk("overflow",    e.inst, a_ovf, e.ovf);
         chk("underflow",   e.inst, a_unf, e.unf);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   initial begin
      rst_n      = 1'b0;
      trig_write = 1'b1;
      trig_read  = 1'b0;
      err_clr    = 1'b0;

      // Trigger held high across reset release: no write.
      repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);

      // Fill past full; then a simultaneous pair at full.
      repeat (5) wr_pulse();
      both_pulse();

      // Clear coincident with a rejected write keeps overflow; a lone clear drops it.
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);

      // Drain past empty.
      repeat (6) rd_pulse();

      // Simultaneous at count 0, then at count 2.
      both_pulse();
      wr_pulse();
      both_pulse();
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (2) rd_pulse();

      // Alternating pairs wrap both address counters.
      repeat (7) begin
         wr_pulse();
         rd_pulse();
      end

      // Level held for 10 clk yields one write.
      repeat (10) drive(1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);

      // Reach count 3, then reset mid-operation: count clears at once.
      repeat (2) wr_pulse();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("async_reset_count", 0, int'(cnt0), 0);
      chk("async_reset_count", 1, int'(cnt1), 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);

      // Random traffic with occasional clears and resets.
      repeat (800) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) != 0));
      end

      repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 0, sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
